// File: rtl/ifu_branch_predictor.sv
// rtl/ifu_branch_predictor.sv - fetch-side BTB predictor with 2-bit counters and mispredict redirect
module ifu_branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int PC_W    = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            lk_vld,
   input  logic [PC_W-1:0] lk_pc,
   output logic            lk_rsp_vld,
   output logic            lk_pred_taken,
   output logic [PC_W-1:0] lk_pred_pc,
   input  logic            ex_rsp_vld,
   output logic            ex_rsp_rdy,
   input  logic            ex_rsp_taken,
   input  logic [PC_W-1:0] ex_rsp_target_pc,
   input  logic [PC_W-1:0] ex_rsp_pc,
   input  logic            ex_rsp_pred_true,
   output logic            redirect_vld,
   output logic [PC_W-1:0] redirect_pc,
   output logic [31:0]     mispred_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - 2 - IDX_W;

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state;
   logic [IDX_W-1:0] clr_ptr;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [PC_W-1:0]    target_q [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];

   logic [IDX_W-1:0] lk_idx;
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] lk_tag;
   logic [TAG_W-1:0] ex_tag;
   logic             lk_hit;
   logic             ex_hit;
   logic             accept;
   logic             unused_low_bits;

   assign lk_idx = lk_pc[IDX_W+1:2];
   assign lk_tag = lk_pc[PC_W-1:IDX_W+2];
   assign ex_idx = ex_rsp_pc[IDX_W+1:2];
   assign ex_tag = ex_rsp_pc[PC_W-1:IDX_W+2];
   assign unused_low_bits = ^{lk_pc[1:0], ex_rsp_pc[1:0]};

   // Table contents are not trusted until INIT has swept every entry.
   assign lk_hit = (state == S_RUN) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag)
                   && ctr_q[lk_idx][1];
   assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

   assign ex_rsp_rdy = (state == S_RUN);
   assign accept     = ex_rsp_vld && ex_rsp_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_INIT;
         clr_ptr <= '0;
      end else if (state == S_INIT) begin
         clr_ptr <= clr_ptr + IDX_W'(1);
         if (clr_ptr == IDX_W'(ENTRIES - 1)) begin
            state <= S_RUN;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lk_rsp_vld    <= 1'b0;
         lk_pred_taken <= 1'b0;
         lk_pred_pc    <= '0;
         redirect_vld  <= 1'b0;
         redirect_pc   <= '0;
         mispred_cnt   <= '0;
      end else begin
         lk_rsp_vld   <= lk_vld;
         redirect_vld <= accept && !ex_rsp_pred_true;
         if (lk_vld) begin
            lk_pred_taken <= lk_hit;
            lk_pred_pc    <= lk_hit ? target_q[lk_idx] : lk_pc + PC_W'(4);
         end
         if (accept && !ex_rsp_pred_true) begin
            redirect_pc <= ex_rsp_target_pc;
            if (mispred_cnt != 32'hFFFF_FFFF) begin
               mispred_cnt <= mispred_cnt + 32'd1;
            end
         end
      end
   end

   // Non-blocking writes give lookups in the same cycle the pre-update entry.
   always_ff @(posedge clk) begin
      if (state == S_INIT) begin
         valid_q[clr_ptr] <= 1'b0;
         ctr_q[clr_ptr]   <= 2'b01;
      end else if (accept) begin
         if (ex_rsp_taken) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= ex_rsp_target_pc;
            if (!ex_hit) begin
               ctr_q[ex_idx] <= 2'b10;
            end else if (ctr_q[ex_idx] != 2'b11) begin
               ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
            end
         end else if (ex_hit && ctr_q[ex_idx] != 2'b00) begin
            ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
         end
      end
   end

endmodule

// File: tb/tb_ifu_branch_predictor.sv
// tb/tb_ifu_branch_predictor.sv - self-checking bench for ifu_branch_predictor
module tb_ifu_branch_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lk_vld = 1'b0;
   logic [31:0] lk_pc = '0;
   logic        lk_rsp_vld;
   logic        lk_pred_taken;
   logic [31:0] lk_pred_pc;
   logic        ex_rsp_vld = 1'b0;
   logic        ex_rsp_rdy;
   logic        ex_rsp_taken = 1'b0;
   logic [31:0] ex_rsp_target_pc = '0;
   logic [31:0] ex_rsp_pc = '0;
   logic        ex_rsp_pred_true = 1'b1;
   logic        redirect_vld;
   logic [31:0] redirect_pc;
   logic [31:0] mispred_cnt;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: table indexed by (pc/4)%16, tag is pc/64.
   bit          m_valid  [16];
   int unsigned m_tag    [16];
   logic [31:0] m_target [16];
   int          m_ctr    [16];
   int          m_cyc;
   bit          e_lk_vld, e_taken, e_redir_vld;
   logic [31:0] e_pc, e_redir_pc, e_cnt;

   ifu_branch_predictor #(.ENTRIES(16), .PC_W(32)) dut (
      .clk(clk), .rst(rst),
      .lk_vld(lk_vld), .lk_pc(lk_pc),
      .lk_rsp_vld(lk_rsp_vld), .lk_pred_taken(lk_pred_taken), .lk_pred_pc(lk_pred_pc),
      .ex_rsp_vld(ex_rsp_vld), .ex_rsp_rdy(ex_rsp_rdy), .ex_rsp_taken(ex_rsp_taken),
      .ex_rsp_target_pc(ex_rsp_target_pc), .ex_rsp_pc(ex_rsp_pc),
      .ex_rsp_pred_true(ex_rsp_pred_true),
      .redirect_vld(redirect_vld), .redirect_pc(redirect_pc), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic assert_reset();
      rst = 1'b1;
      lk_vld = 1'b0;
      ex_rsp_vld = 1'b0;
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_cyc = 0;
      e_lk_vld = 0; e_taken = 0; e_redir_vld = 0;
      e_pc = '0; e_redir_pc = '0; e_cnt = '0;
      #2;
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Advance one clock, predicting outputs from the model state before the edge.
   task automatic tick();
      int i;
      int unsigned t;
      bit hit;
      e_lk_vld = lk_vld;
      if (lk_vld) begin
         i = int'((lk_pc >> 2) % 16);
         t = lk_pc >> 6;
         if (m_cyc >= 16 && m_valid[i] && m_tag[i] == t && m_ctr[i] >= 2) begin
            e_taken = 1'b1; e_pc = m_target[i];
         end else begin
            e_taken = 1'b0; e_pc = lk_pc + 32'd4;
         end
      end
      e_redir_vld = 1'b0;
      if (ex_rsp_vld && m_cyc >= 16) begin
         i = int'((ex_rsp_pc >> 2) % 16);
         t = ex_rsp_pc >> 6;
         hit = m_valid[i] && m_tag[i] == t;
         if (ex_rsp_taken) begin
            m_ctr[i] = hit ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1) : 2;
            m_valid[i] = 1'b1; m_tag[i] = t; m_target[i] = ex_rsp_target_pc;
         end else if (hit && m_ctr[i] > 0) begin
            m_ctr[i] = m_ctr[i] - 1;
         end
         if (!ex_rsp_pred_true) begin
            e_redir_vld = 1'b1; e_redir_pc = ex_rsp_target_pc;
            if (e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 32'd1;
         end
      end
      if (m_cyc < 16) m_cyc++;
      @(posedge clk); #1;
      lk_vld = 1'b0;
      ex_rsp_vld = 1'b0;
   endtask

   task automatic set_ex(input logic [31:0] pc, input bit taken, input logic [31:0] tgt,
                         input bit pt);
      ex_rsp_vld = 1'b1; ex_rsp_pc = pc; ex_rsp_taken = taken;
      ex_rsp_target_pc = tgt; ex_rsp_pred_true = pt;
   endtask

   task automatic lookup(input logic [31:0] pc, input bit exp_taken, input logic [31:0] exp_pc,
                         input string name);
      lk_vld = 1'b1; lk_pc = pc;
      tick();
      n_vec++;
      if (lk_rsp_vld !== 1'b1 || lk_pred_taken !== exp_taken || lk_pred_pc !== exp_pc) begin
         n_err++;
         $display("FAIL %s: got vld=%0b taken=%0b pc=%h, want vld=1 taken=%0b pc=%h",
                  name, lk_rsp_vld, lk_pred_taken, lk_pred_pc, exp_taken, exp_pc);
      end
   endtask

   task automatic test_reset();
      assert_reset();
      n_vec++;
      if ({lk_rsp_vld, lk_pred_taken, ex_rsp_rdy, redirect_vld} !== 4'b0 ||
          lk_pred_pc !== 32'h0 || redirect_pc !== 32'h0 || mispred_cnt !== 32'h0) begin
         n_err++;
         $display("FAIL reset_values: got vld=%0b tk=%0b rdy=%0b rv=%0b pp=%h rp=%h cnt=%0d, want all 0",
                  lk_rsp_vld, lk_pred_taken, ex_rsp_rdy, redirect_vld, lk_pred_pc, redirect_pc, mispred_cnt);
      end
      release_reset();
      for (int c = 0; c < 16; c++) begin
         n_vec++;
         if (ex_rsp_rdy !== 1'b0) begin
            n_err++; $display("FAIL init_rdy cycle %0d: got %0b want 0", c, ex_rsp_rdy);
         end
         if (c == 3) begin lk_vld = 1'b1; lk_pc = 32'h100; end
         if (c == 5) set_ex(32'h200, 1'b1, 32'h180, 1'b0);
         tick();
         if (c == 3) begin
            n_vec++;
            if (lk_rsp_vld !== 1'b1 || lk_pred_taken !== 1'b0 || lk_pred_pc !== 32'h104) begin
               n_err++;
               $display("FAIL init_lookup: got vld=%0b taken=%0b pc=%h, want 1 0 00000104",
                        lk_rsp_vld, lk_pred_taken, lk_pred_pc);
            end
         end
         if (c == 5) begin
            n_vec++;
            if (redirect_vld !== 1'b0 || mispred_cnt !== 32'd0) begin
               n_err++;
               $display("FAIL init_ex_ignored: got redirect=%0b cnt=%0d, want 0 0",
                        redirect_vld, mispred_cnt);
            end
         end
      end
      n_vec++;
      if (ex_rsp_rdy !== 1'b1) begin
         n_err++; $display("FAIL run_rdy cycle 16: got %0b want 1", ex_rsp_rdy);
      end
   endtask

   task automatic test_cold_taken();
      set_ex(32'h200, 1'b1, 32'h180, 1'b0);
      tick();
      n_vec++;
      if (redirect_vld !== 1'b1 || redirect_pc !== 32'h180 || mispred_cnt !== 32'd1) begin
         n_err++;
         $display("FAIL cold_redirect: got rv=%0b rp=%h cnt=%0d, want 1 00000180 1",
                  redirect_vld, redirect_pc, mispred_cnt);
      end
      tick();
      n_vec++;
      if (redirect_vld !== 1'b0 || redirect_pc !== 32'h180) begin
         n_err++;
         $display("FAIL redirect_pulse_end: got rv=%0b rp=%h, want 0 00000180",
                  redirect_vld, redirect_pc);
      end
      lookup(32'h200, 1'b1, 32'h180, "cold_lookup");
   endtask

   task automatic test_hysteresis();
      set_ex(32'h200, 1'b0, 32'h204, 1'b1); tick();
      set_ex(32'h200, 1'b0, 32'h204, 1'b1); tick();
      lookup(32'h200, 1'b0, 32'h204, "hyst_ctr00");
      set_ex(32'h200, 1'b1, 32'h180, 1'b1); tick();
      lookup(32'h200, 1'b0, 32'h204, "hyst_ctr01");
      set_ex(32'h200, 1'b1, 32'h180, 1'b1); tick();
      lookup(32'h200, 1'b1, 32'h180, "hyst_ctr10");
   endtask

   task automatic test_aliasing();
      set_ex(32'h200, 1'b1, 32'h180, 1'b1); tick();
      lookup(32'h240, 1'b0, 32'h244, "alias_miss");
      set_ex(32'h240, 1'b1, 32'h300, 1'b0); tick();
      lookup(32'h240, 1'b1, 32'h300, "alias_new_owner");
      lookup(32'h200, 1'b0, 32'h204, "alias_evicted");
   endtask

   task automatic test_simultaneous();
      set_ex(32'h200, 1'b1, 32'h180, 1'b0);
      lookup(32'h200, 1'b0, 32'h204, "same_cycle_lookup");
      lookup(32'h200, 1'b1, 32'h180, "next_cycle_lookup");
   endtask

   task automatic test_back_to_back();
      set_ex(32'h300, 1'b1, 32'h400, 1'b0); tick();
      n_vec++;
      if (redirect_vld !== 1'b1 || redirect_pc !== 32'h400 || mispred_cnt !== 32'd4) begin
         n_err++;
         $display("FAIL b2b_first: got rv=%0b rp=%h cnt=%0d, want 1 00000400 4",
                  redirect_vld, redirect_pc, mispred_cnt);
      end
      set_ex(32'h304, 1'b1, 32'h500, 1'b0); tick();
      n_vec++;
      if (redirect_vld !== 1'b1 || redirect_pc !== 32'h500 || mispred_cnt !== 32'd5) begin
         n_err++;
         $display("FAIL b2b_second: got rv=%0b rp=%h cnt=%0d, want 1 00000500 5",
                  redirect_vld, redirect_pc, mispred_cnt);
      end
      tick();
      n_vec++;
      if (redirect_vld !== 1'b0 || redirect_pc !== 32'h500) begin
         n_err++;
         $display("FAIL b2b_hold: got rv=%0b rp=%h, want 0 00000500", redirect_vld, redirect_pc);
      end
   endtask

   task automatic test_reset_mid_run();
      int n;
      @(posedge clk); #1;
      assert_reset();
      n_vec++;
      if (mispred_cnt !== 32'd0 || redirect_vld !== 1'b0 || ex_rsp_rdy !== 1'b0) begin
         n_err++;
         $display("FAIL midrun_reset: got cnt=%0d rv=%0b rdy=%0b, want 0 0 0",
                  mispred_cnt, redirect_vld, ex_rsp_rdy);
      end
      release_reset();
      n = 0;
      while (ex_rsp_rdy !== 1'b1 && n < 40) begin tick(); n++; end
      n_vec++;
      if (n != 16) begin
         n_err++; $display("FAIL reinit_length: got %0d cycles want 16", n);
      end
      lookup(32'h200, 1'b0, 32'h204, "cleared_entry");
      lookup(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, "pc_wrap");
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         lk_vld = 1'($urandom % 2);
         lk_pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | ($urandom % 4);
         ex_rsp_vld   = 1'($urandom % 2);
         ex_rsp_pc    = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
         ex_rsp_taken = 1'($urandom % 2);
         ex_rsp_target_pc = ex_rsp_taken ? ($urandom & 32'hFFFF_FFFC) : ex_rsp_pc + 32'd4;
         ex_rsp_pred_true = 1'($urandom % 2);
         tick();
         n_vec++;
         if (lk_rsp_vld !== e_lk_vld || lk_pred_taken !== e_taken || lk_pred_pc !== e_pc ||
             redirect_vld !== e_redir_vld || redirect_pc !== e_redir_pc ||
             mispred_cnt !== e_cnt || ex_rsp_rdy !== (m_cyc >= 16)) begin
            n_err++;
            $display("FAIL random cycle %0d: got lv=%0b tk=%0b pp=%h rv=%0b rp=%h cnt=%0d rdy=%0b, want lv=%0b tk=%0b pp=%h rv=%0b rp=%h cnt=%0d rdy=%0b",
                     c, lk_rsp_vld, lk_pred_taken, lk_pred_pc, redirect_vld, redirect_pc,
                     mispred_cnt, ex_rsp_rdy, e_lk_vld, e_taken, e_pc, e_redir_vld,
                     e_redir_pc, e_cnt, m_cyc >= 16);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cold_taken();
      test_hysteresis();
      test_aliasing();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
